// File: rtl/solver_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : solver_sample_capture
// Purpose  : Decimating sample logger for the RK4 motor solver. Each kept
//            solver step {w, i} is tagged with a sequence number and queued in
//            a first-word-fall-through FIFO that drains through a valid/ready
//            read port toward the register/DMA side.
// Revision : 1.0 - initial release
// ============================================================================
module solver_sample_capture #(
  parameter int DEPTH   = 16,
  parameter int DECIM_W = 16,
  parameter int SEQ_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic [31:0]              i_in,
  input  logic [31:0]              w_in,
  input  logic                     enable,
  input  logic                     oneshot,
  input  logic [DECIM_W-1:0]       decim,
  input  logic                     clr_overflow,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [63:0]              rd_data,
  output logic [SEQ_W-1:0]         rd_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_enter_run;

  logic [DECIM_W-1:0]  r_dec_cnt;
  logic [SEQ_W-1:0]    r_seq;
  logic [c_CW-1:0]     r_cap_cnt;
  logic [c_CW-1:0]     w_cap_cnt_nxt;
  logic                w_cap_inc;
  logic                w_cap_full;

  logic [63:0]         r_mem_data [DEPTH];
  logic [SEQ_W-1:0]    r_mem_seq  [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_CW-1:0]     r_count;
  logic                r_overflow;

  logic                w_strobe;
  logic                w_kept;
  logic                w_pop;
  logic                w_fifo_full;
  logic                w_write;
  logic                w_drop;

  // Capture qualification: only RUN listens to the solver, and a finished
  // one-shot run stops accepting strobes even before it reaches DONE.
  assign w_cap_full  = (r_cap_cnt == c_DEPTH_CNT);
  assign w_strobe    = sample_valid && (r_state == ST_RUN) && !(oneshot && w_cap_full);
  assign w_kept      = w_strobe && (r_dec_cnt == '0);

  // FIFO handshake: a full FIFO can still accept a write when the head leaves
  // in the same cycle.
  assign rd_valid    = (r_count != '0);
  assign w_pop       = rd_valid && rd_ready;
  assign w_fifo_full = (r_count == c_DEPTH_CNT);
  assign w_write     = w_kept && (!w_fifo_full || w_pop);
  assign w_drop      = w_kept && !w_write;

  // Capture counter saturates at DEPTH so a long continuous run cannot wrap it.
  assign w_cap_inc     = w_write && !w_cap_full;
  assign w_cap_cnt_nxt = r_cap_cnt + {{(c_CW-1){1'b0}}, w_cap_inc};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; one-shot completion is judged on the post-write count so
  // DONE follows the DEPTH-th write immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_run = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable) begin
          w_state_nxt = ST_RUN;
          w_enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (oneshot && (w_cap_cnt_nxt == c_DEPTH_CNT)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decimation and capture counters; entering RUN guarantees the first strobe is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_cnt <= '0;
      r_cap_cnt <= '0;
    end else if (w_enter_run) begin
      r_dec_cnt <= '0;
      r_cap_cnt <= '0;
    end else begin
      if (w_strobe) begin
        if (r_dec_cnt == '0) begin
          r_dec_cnt <= decim;
        end else begin
          r_dec_cnt <= r_dec_cnt - DECIM_W'(1);
        end
      end
      r_cap_cnt <= w_cap_cnt_nxt;
    end
  end

  // Sequence tag advances on every kept sample, so dropped samples leave gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= '0;
    end else if (w_kept) begin
      r_seq <= r_seq + SEQ_W'(1);
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_data[r_wr_ptr] <= {w_in, i_in};
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Head of the FIFO is presented directly; zero while empty.
  always_comb begin
    rd_data = '0;
    rd_seq  = '0;
    if (rd_valid) begin
      rd_data = r_mem_data[r_rd_ptr];
      rd_seq  = r_mem_seq[r_rd_ptr];
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;
  assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_solver_sample_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_solver_sample_capture
// Purpose  : Self-checking bench for solver_sample_capture: a vector table,
//            directed multi-cycle sequences and a randomized run, all compared
//            with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_solver_sample_capture;

  localparam int DEPTH   = 16;
  localparam int DECIM_W = 16;
  localparam int SEQ_W   = 16;
  localparam int CW      = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic [31:0]        i_in;
  logic [31:0]        w_in;
  logic               enable;
  logic               oneshot;
  logic [DECIM_W-1:0] decim;
  logic               clr_overflow;
  logic               rd_ready;
  logic               rd_valid;
  logic [63:0]        rd_data;
  logic [SEQ_W-1:0]   rd_seq;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               done;

  always #5 clk = ~clk;

  solver_sample_capture #(.DEPTH(DEPTH), .DECIM_W(DECIM_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .i_in(i_in), .w_in(w_in),
    .enable(enable), .oneshot(oneshot), .decim(decim), .clr_overflow(clr_overflow),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .rd_seq(rd_seq),
    .count(count), .overflow(overflow), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of tagged samples ----------------
  typedef struct {
    logic [63:0] d;
    logic [15:0] s;
  } ent_t;

  ent_t        mq[$];
  int          m_mode;      // 0 idle, 1 running, 2 finished
  int          m_skip;      // strobes still to skip before the next keep
  logic [15:0] m_seq;
  int          m_cap;
  bit          m_ovf;
  bit          m_pop, m_kept, m_wr;
  bit          auto_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_mode = 0; m_skip = 0; m_seq = '0; m_cap = 0; m_ovf = 1'b0;
    end else begin
      m_pop  = (mq.size() > 0) && rd_ready;
      m_kept = 1'b0;
      if (m_mode == 1 && sample_valid && !(oneshot && m_cap >= DEPTH)) begin
        if (m_skip == 0) begin
          m_kept = 1'b1;
          m_skip = int'(decim);
        end else begin
          m_skip = m_skip - 1;
        end
      end
      m_wr = m_kept && ((mq.size() < DEPTH) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_wr) begin
        mq.push_back('{d: {w_in, i_in}, s: m_seq});
        if (m_cap < DEPTH) m_cap = m_cap + 1;
      end
      if (m_kept) m_seq = m_seq + 16'd1;
      if (m_kept && !m_wr) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_skip = 0; m_cap = 0; end
        1: if (!enable) m_mode = 0; else if (oneshot && m_cap >= DEPTH) m_mode = 2;
        default: if (!enable) m_mode = 0;
      endcase
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (auto_en) begin
      chk("mdl_valid", rd_valid, mq.size() > 0);
      chk("mdl_count", count, mq.size());
      chk("mdl_data",  rd_data, (mq.size() > 0) ? mq[0].d : 64'd0);
      chk("mdl_seq",   rd_seq,  (mq.size() > 0) ? mq[0].s : 16'd0);
      chk("mdl_ovf",   overflow, m_ovf);
      chk("mdl_done",  done, m_mode == 2);
    end
  end

  // Pop monitor for the one-shot sequence.
  bit          mon_en = 1'b0;
  int          pops = 0;
  logic [15:0] last_seq = '0;
  always @(negedge clk) begin
    if (mon_en && rd_valid && rd_ready) begin
      pops++;
      last_seq = rd_seq;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; enable = 1'b0; oneshot = 1'b0; decim = '0;
    clr_overflow = 1'b0; rd_ready = 1'b0; i_in = '0; w_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic strobe(input logic [31:0] iv, input logic [31:0] wv);
    sample_valid = 1'b1; i_in = iv; w_in = wv;
    tick();
    sample_valid = 1'b0;
  endtask

  typedef struct {
    bit          sv;
    bit          rdy;
    bit          ev;
    logic [4:0]  ecnt;
    logic [15:0] eseq;
    logic [63:0] edata;
  } vec_t;

  vec_t tv[10];
  localparam logic [63:0] D1 = 64'h4000_0000_3F80_0000;

  initial begin
    // Vector table: enable edge, three strobes, then pops incl. push+pop and empty pop.
    tv[0] = '{1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 64'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 5'd1, 16'd0, D1};
    tv[2] = '{1'b1, 1'b0, 1'b1, 5'd2, 16'd0, D1};
    tv[3] = '{1'b1, 1'b0, 1'b1, 5'd3, 16'd0, D1};
    tv[4] = '{1'b0, 1'b0, 1'b1, 5'd3, 16'd0, D1};
    tv[5] = '{1'b0, 1'b1, 1'b1, 5'd2, 16'd1, D1};
    tv[6] = '{1'b1, 1'b1, 1'b1, 5'd2, 16'd2, D1};
    tv[7] = '{1'b0, 1'b1, 1'b1, 5'd1, 16'd3, D1};
    tv[8] = '{1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 64'd0};
    tv[9] = '{1'b0, 1'b1, 1'b0, 5'd0, 16'd0, 64'd0};

    // ---- reset state ----
    do_reset();
    auto_en = 1'b1;
    chk("rst_valid", rd_valid, 1'b0);
    chk("rst_data", rd_data, 64'd0);
    chk("rst_seq", rd_seq, 16'd0);
    chk("rst_count", count, 5'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_done", done, 1'b0);

    // ---- table-driven basic capture ----
    enable = 1'b1; decim = '0; i_in = 32'h3F80_0000; w_in = 32'h4000_0000;
    for (int k = 0; k < 10; k++) begin
      sample_valid = tv[k].sv;
      rd_ready     = tv[k].rdy;
      tick();
      chk($sformatf("tv%0d_valid", k), rd_valid, tv[k].ev);
      chk($sformatf("tv%0d_count", k), count, tv[k].ecnt);
      chk($sformatf("tv%0d_seq", k), rd_seq, tv[k].eseq);
      chk($sformatf("tv%0d_data", k), rd_data, tv[k].edata);
    end
    sample_valid = 1'b0; rd_ready = 1'b0;

    // ---- decimation by 4: keeps strobes 1, 5, 9 ----
    do_reset();
    enable = 1'b1; decim = 16'd3;
    tick();
    for (int k = 1; k <= 12; k++) strobe(32'(k), 32'hA000_0000 + 32'(k));
    chk("dec_count", count, 5'd3);
    for (int e = 0; e < 3; e++) begin
      chk($sformatf("dec%0d_valid", e), rd_valid, 1'b1);
      chk($sformatf("dec%0d_seq", e), rd_seq, 16'(e));
      chk($sformatf("dec%0d_i", e), rd_data[31:0], 32'(1 + 4 * e));
      rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    end
    chk("dec_empty", rd_valid, 1'b0);

    // ---- overflow: 20 kept strobes into 16 entries ----
    do_reset();
    enable = 1'b1; decim = '0;
    tick();
    for (int k = 0; k < 20; k++) strobe(32'(k), ~32'(k));
    chk("ovf_count", count, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_head_seq", rd_seq, 16'd0);
    chk("ovf_head_i", rd_data[31:0], 32'd0);
    rd_ready = 1'b1; repeat (16) tick(); rd_ready = 1'b0;
    chk("ovf_drained", count, 5'd0);
    chk("ovf_sticky", overflow, 1'b1);
    strobe(32'd100, 32'd0);
    chk("ovf_gap_tag", rd_seq, 16'd20);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    for (int k = 0; k < 15; k++) strobe(32'(200 + k), 32'd0);
    chk("ovf_refull", count, 5'd16);
    chk("ovf_refull_flag", overflow, 1'b0);
    sample_valid = 1'b1; clr_overflow = 1'b1; tick();
    sample_valid = 1'b0; clr_overflow = 1'b0;
    chk("ovf_set_beats_clr", overflow, 1'b1);

    // ---- full FIFO with simultaneous pop and kept strobe ----
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    sample_valid = 1'b1; rd_ready = 1'b1; i_in = 32'hCAFE_0001; w_in = 32'h1234_5678;
    tick();
    sample_valid = 1'b0; rd_ready = 1'b0;
    chk("fullpp_count", count, 5'd16);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_head", rd_seq, 16'd21);
    rd_ready = 1'b1; repeat (15) tick(); rd_ready = 1'b0;
    chk("fullpp_tail_seq", rd_seq, 16'd37);
    chk("fullpp_tail_data", rd_data, 64'h1234_5678_CAFE_0001);
    chk("fullpp_tail_cnt", count, 5'd1);

    // ---- one-shot: stops after exactly DEPTH writes ----
    do_reset();
    enable = 1'b1; oneshot = 1'b1; rd_ready = 1'b1;
    tick();
    pops = 0; mon_en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      strobe(32'(k), 32'd0);
      if (k == 15) chk("os_done_early", done, 1'b0);
      if (k == 16) chk("os_done_16", done, 1'b1);
    end
    tick(); tick();
    mon_en = 1'b0;
    chk("os_done", done, 1'b1);
    chk("os_pops", pops, 16);
    chk("os_last_seq", last_seq, 16'd15);
    chk("os_count", count, 5'd0);
    enable = 1'b0; tick();
    chk("os_idle_done", done, 1'b0);
    rd_ready = 1'b0; oneshot = 1'b0;

    // ---- sequence wrap and mid-stream reset ----
    do_reset();
    enable = 1'b1; decim = '0; rd_ready = 1'b1;
    tick();
    sample_valid = 1'b1;
    repeat (65534) tick();
    sample_valid = 1'b0;
    tick();
    rd_ready = 1'b0;
    chk("wrap_empty", count, 5'd0);
    for (int k = 0; k < 3; k++) strobe(32'(k), 32'd0);
    chk("wrap_tag0", rd_seq, 16'hFFFE);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("wrap_tag1", rd_seq, 16'hFFFF);
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    chk("wrap_tag2", rd_seq, 16'h0000);
    strobe(32'd7, 32'd7);
    strobe(32'd8, 32'd8);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_count", count, 5'd0);
    chk("midrst_valid", rd_valid, 1'b0);
    tick();
    strobe(32'd9, 32'd9);
    chk("midrst_tag", rd_seq, 16'd0);

    // ---- randomized run against the model ----
    for (int n = 0; n < 5000; n++) begin
      rst          = ($urandom_range(0, 499) == 0);
      sample_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) oneshot = ~oneshot;
      if ($urandom_range(0, 31) == 0) decim = 16'($urandom_range(0, 3));
      rd_ready     = ($urandom_range(0, 2) == 0);
      clr_overflow = ($urandom_range(0, 7) == 0);
      i_in         = $urandom;
      w_in         = $urandom;
      tick();
    end
    rst = 1'b0;
    tick();
    auto_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
